// File: rtl/credit_to_valrdy_fifo.sv
// rtl/credit_to_valrdy_fifo.sv - credit/yummy ingress to valid/ready egress through a circular FIFO
// Credits go back upstream only when a flit leaves downstream, so upstream never overruns DEPTH.
module credit_to_valrdy_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  yummy_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [CNT_W-1:0]      occupancy,
  output logic                  overflow_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  yummy_q, yummy_d;
  logic                  ovf_q, ovf_d;
  logic                  push, pop;

  assign valid_out    = (count_q != '0);
  assign data_out     = mem_q[rd_ptr_q];
  assign occupancy    = count_q;
  assign yummy_out    = yummy_q;
  assign overflow_err = ovf_q;

  // A full FIFO still accepts a flit when the head leaves in the same cycle.
  assign pop  = valid_out && ready_in;
  assign push = valid_in && ((count_q < CNT_W'(DEPTH)) || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    yummy_d  = pop;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    if (valid_in && !push) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      yummy_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      yummy_q  <= yummy_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is intentionally unreset; valid_out gates its meaning.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_credit_to_valrdy_fifo.sv
// tb/tb_credit_to_valrdy_fifo.sv - vector table plus queue scoreboard for credit_to_valrdy_fifo
module tb_credit_to_valrdy_fifo;
  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          yummy_out;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          ready_in;
  logic [CW-1:0] occupancy;
  logic          overflow_err;

  credit_to_valrdy_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .yummy_out(yummy_out), .data_out(data_out), .valid_out(valid_out),
    .ready_in(ready_in), .occupancy(occupancy), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          vi;
    logic          ri;
    logic [DW-1:0] d;
    logic          ev;
    logic [DW-1:0] ed;
    int            eocc;
    logic          ey;
    logic          eovf;
  } vec_t;

  vec_t          tbl [14];
  logic [DW-1:0] m_q [$];
  logic          m_y;
  logic          m_ovf;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_yummy;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_compare();
    check("sb_valid", DW'(valid_out), DW'(m_q.size() != 0));
    if (m_q.size() != 0) check("sb_data", data_out, m_q[0]);
    check("sb_occ", DW'(occupancy), DW'(m_q.size()));
    check("sb_yummy", DW'(yummy_out), DW'(m_y));
    check("sb_ovf", DW'(overflow_err), DW'(m_ovf));
  endtask

  task automatic cycle(input logic vi, input logic [DW-1:0] d, input logic ri);
    logic pop, push;
    @(negedge clk);
    reset = 1'b1; valid_in = vi; data_in = d; ready_in = ri;
    pop  = (m_q.size() != 0) && ri;
    push = vi && ((m_q.size() < DEPTH) || pop);
    @(posedge clk); #1;
    m_y = pop;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(d);
    if (vi && !push) m_ovf = 1'b1;
    sb_compare();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; valid_in = 1'b0; ready_in = 1'b0; data_in = '0;
    @(posedge clk); #1;
    m_q.delete(); m_y = 1'b0; m_ovf = 1'b0;
    check("rst_valid", DW'(valid_out), '0);
    check("rst_occ", DW'(occupancy), '0);
    check("rst_yummy", DW'(yummy_out), '0);
    check("rst_ovf", DW'(overflow_err), '0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 64'hA5, 1'b1, 64'hA5, 1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 64'h0,  1'b0, 64'h0,  0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 64'h0,  1'b0, 64'h0,  0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 64'h1,  1'b1, 64'h1,  1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 64'h2,  1'b1, 64'h1,  2, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 64'h3,  1'b1, 64'h1,  3, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 64'h4,  1'b1, 64'h1,  4, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 64'h5,  1'b1, 64'h2,  4, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 64'hFF, 1'b1, 64'h2,  4, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 64'h0,  1'b1, 64'h3,  3, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 64'h0,  1'b1, 64'h4,  2, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 64'h0,  1'b1, 64'h5,  1, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 64'h0,  1'b0, 64'h0,  0, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 64'h0,  1'b0, 64'h0,  0, 1'b0, 1'b1};

    reset = 1'b0; valid_in = 1'b0; ready_in = 1'b0; data_in = '0;
    m_y = 1'b0; m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].vi, tbl[i].d, tbl[i].ri);
      check($sformatf("vec%0d_valid", i), DW'(valid_out), DW'(tbl[i].ev));
      if (tbl[i].ev) check($sformatf("vec%0d_data", i), data_out, tbl[i].ed);
      check($sformatf("vec%0d_occ", i), DW'(occupancy), DW'(tbl[i].eocc));
      check($sformatf("vec%0d_yummy", i), DW'(yummy_out), DW'(tbl[i].ey));
      check($sformatf("vec%0d_ovf", i), DW'(overflow_err), DW'(tbl[i].eovf));
    end

    do_reset();
    n_yummy = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, DW'(64'h1000 + i), 1'b1);
      if (yummy_out) n_yummy++;
      check("stream_occ", DW'(occupancy), DW'(1));
    end
    repeat (2) begin
      cycle(1'b0, '0, 1'b1);
      if (yummy_out) n_yummy++;
    end
    check("stream_yummy_total", DW'(n_yummy), DW'(100));

    for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(64'h20 + i), 1'b0);
    cycle(1'b1, 64'hEE, 1'b0);
    cycle(1'b0, '0, 1'b1);
    check("pre_rst_occ", DW'(occupancy), DW'(3));
    check("pre_rst_yummy", DW'(yummy_out), DW'(1));
    check("pre_rst_ovf", DW'(overflow_err), DW'(1));
    do_reset();
    cycle(1'b1, 64'h77, 1'b0);
    check("post_rst_data", data_out, 64'h77);
    check("post_rst_occ", DW'(occupancy), DW'(1));
    cycle(1'b0, '0, 1'b1);
    check("post_rst_yummy", DW'(yummy_out), DW'(1));
    cycle(1'b0, '0, 1'b0);
    check("post_rst_empty", DW'(valid_out), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/credit_to_valrdy_fifo.md
Name: credit_to_valrdy_fifo

Overview:
Parametrised credit-to-valid/ready converter for on-chip NoC-to-AXI-style egress.
- Upstream side is a credit/yummy link; downstream side is valid/ready.
- Flits are held in a DEPTH-entry circular FIFO; one yummy is returned per flit accepted downstream (true credit return, not on arrival).
- Streams continuously with no idle/drain phases; full throughput of one flit per cycle in and out simultaneously.

Parameters:
DATA_WIDTH, 64, flit width in bits.
DEPTH, 4, FIFO entries; power of two, >= 2; equals the upstream initial credit count.
CNT_W, $clog2(DEPTH)+1, derived occupancy width; not overridden.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-low reset.
data_in  input  DATA_WIDTH  flit from credit link.
valid_in  input  1  flit present on data_in this cycle.
yummy_out  output  1  one-cycle credit-return pulse to upstream.
data_out  output  DATA_WIDTH  head-of-FIFO flit.
valid_out  output  1  head flit valid.
ready_in  input  1  downstream accepts flit when valid_out && ready_in.
occupancy  output  CNT_W  current number of stored flits, 0..DEPTH.
overflow_err  output  1  sticky: flit arrived with no free entry.

Behaviour:
- Reset (reset==0 at posedge):
  - wr_ptr, rd_ptr, count = 0; yummy_out = 0; overflow_err = 0.
  - valid_out = 0 (derived from count).
  - Memory contents are not reset; data_out is don't-care while valid_out==0.
- Mid-operation reset discards all stored flits and any pending yummy. Upstream is reset by the same reset and restores DEPTH credits.
- push = valid_in && (count < DEPTH || pop).
- pop = valid_out && ready_in.
- valid_out = (count != 0). data_out = mem[rd_ptr], driven combinationally from registered storage.
- Latency: a flit written at edge N is visible on valid_out/data_out in the cycle after edge N. There is no input-to-output bypass.
- Push writes mem[wr_ptr] and increments wr_ptr modulo DEPTH.
- Pop increments rd_ptr modulo DEPTH. Pointers wrap silently.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on push+pop in the same cycle.
- Full with simultaneous pop: the push is accepted. Its write slot is the entry freed by the pop (wr_ptr == rd_ptr), and the read of the old head occurs in the same cycle, so there is no hazard.
- Overflow (valid_in && count==DEPTH && !pop):
  - flit dropped; count and pointers unchanged.
  - overflow_err set to 1 and held until reset.
  - no yummy generated.
- yummy_out is registered: yummy_out <= pop. It pulses exactly one cycle after each accepted output flit. Back-to-back pops give a continuous yummy_out high, one credit per cycle.
- Credit invariant (upstream credits + count + pending yummy == DEPTH) holds whenever overflow_err==0.
- valid_out must not drop while ready_in is low (data_out is stable until popped), per valid/ready rules.
- No ready_in combinational path to any output except through registered state. data_out/valid_out depend only on registers.
- occupancy = count.

Test Plan:
- Reset then single flit: valid_in=1 with data 0xA5 for 1 cycle, ready_in=1. valid_out=1 with data_out=0xA5 one cycle later. yummy_out pulses the cycle after the pop. occupancy returns to 0.
- Fill and stall: DEPTH=4, ready_in=0, push 0x1..0x4. occupancy=4 and no yummy_out. Raise ready_in: flits out in order 1,2,3,4 on consecutive cycles, yummy_out high for 4 consecutive cycles.
- Streaming at full rate: valid_in=1 and ready_in=1 for 100 cycles with incrementing data. Output is in order with no gaps after the first cycle, occupancy stays at 1, and 100 yummies are returned total.
- Full with simultaneous push/pop: at occupancy=4, drive ready_in=1 and valid_in=1 (data 0x5) in the same cycle. occupancy stays 4, 0x5 is delivered after 0x2..0x4, overflow_err stays 0.
- Overflow: at occupancy=4, drive ready_in=0 and valid_in=1 (data 0xFF). overflow_err=1 (sticky), occupancy=4, 0xFF never appears on data_out.
- Reset mid-stream: assert reset low for 1 cycle with occupancy=3. Next cycle valid_out=0, occupancy=0, yummy_out=0, overflow_err=0. A new flit 0x77 then passes through correctly with wrapped pointers.
